fp_mul_arbiter: RTL and testbench

- Shares one fp_multiplier datapath between NUM_REQ independent requesters.
- Accepts an operand pair from a requester using round-robin arbitration.
- Sequences the multiplier's three strobe/ack transfers in order: operand A, operand B, product.
- Returns the product to the requester that issued it; sits between the FP issue logic and the single multiplier instance.

---
 rtl/fp_arb_pkg.sv | 20 ++
 rtl/fp_mul_arbiter_rr_picker.sv | 32 +++
 rtl/fp_mul_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared state encoding, operand-pair payload and constants for fp_mul_arbiter.
package fp_arb_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_PROD,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

endpackage

// File: rtl/fp_mul_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_c,
  output logic [IDX_W-1:0]   gnt_idx_c,
  output logic               any_c
);

  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] sel;
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_i) + k) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!any_c && req_i[sel]) begin
        any_c          = 1'b1;
        gnt_oh_c[sel]  = 1'b1;
        gnt_idx_c      = sel;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one strobe/ack FP multiplier among NUM_REQ requesters, one op in flight.
// Optional watchdog with mul_abort output when FP_ARB_WDOG_EN is defined.
module fp_mul_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [FP_W-1:0]         resp_data,
  output logic                    resp_err,
  output logic [FP_W-1:0]         mul_a,
  output logic                    mul_a_stb,
  input  logic                    mul_a_ack,
  output logic [FP_W-1:0]         mul_b,
  output logic                    mul_b_stb,
  input  logic                    mul_b_ack,
  input  logic [FP_W-1:0]         mul_prod,
  input  logic                    mul_prod_stb,
  output logic                    mul_prod_ack,
`ifdef FP_ARB_WDOG_EN
  output logic                    mul_abort,
`endif
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("fp_mul_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  fp_pair_t           op_q, op_d;
  logic [FP_W-1:0]    resp_data_q, resp_data_d;
  logic               mul_a_stb_q, mul_a_stb_d;
  logic               mul_b_stb_q, mul_b_stb_d;
  logic               mul_prod_ack_q, mul_prod_ack_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  fp_pair_t           req_pair [NUM_REQ];

`ifdef FP_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              abort_q, abort_d;
  logic              resp_err_q, resp_err_d;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pair
    assign req_pair[gi] = {req_a[gi*FP_W +: FP_W], req_b[gi*FP_W +: FP_W]};
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_c  (pick_oh),
    .gnt_idx_c (pick_idx),
    .any_c     (pick_any)
  );

  // Next state; output registers are derived from the next state at the end.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    gnt_oh_d    = gnt_oh_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    req_ready_d = '0;
`ifdef FP_ARB_WDOG_EN
    wdog_d      = wdog_q;
    abort_d     = 1'b0;
    resp_err_d  = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = SEND_A;
          op_d        = req_pair[pick_idx];
          req_ready_d = pick_oh;
          grant_id_d  = pick_idx;
          gnt_oh_d    = pick_oh;
          rr_ptr_d    = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
      end
      SEND_A:    if (mul_a_stb_q && mul_a_ack) state_d = SEND_B;
      SEND_B:    if (mul_b_stb_q && mul_b_ack) state_d = WAIT_PROD;
      WAIT_PROD: begin
        if (mul_prod_ack_q && mul_prod_stb) begin
          resp_data_d = mul_prod;
          state_d     = RESP;
        end
      end
      RESP:      if ((resp_valid_q & resp_ready) != '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`ifdef FP_ARB_WDOG_EN
    // Watchdog overrides whatever the multiplier handshake did this cycle.
    if (state_q == IDLE) begin
      wdog_d = '0;
      if (pick_any) resp_err_d = 1'b0;
    end else if (state_q inside {SEND_A, SEND_B, WAIT_PROD}) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RESP;
        resp_data_d = FP_QNAN;
        resp_err_d  = 1'b1;
        abort_d     = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
    mul_a_stb_d    = (state_d == SEND_A);
    mul_b_stb_d    = (state_d == SEND_B);
    mul_prod_ack_d = (state_d == WAIT_PROD);
    resp_valid_d   = (state_d == RESP) ? gnt_oh_d : '0;
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      gnt_oh_q       <= '0;
      req_ready_q    <= '0;
      resp_valid_q   <= '0;
      op_q           <= '0;
      resp_data_q    <= '0;
      mul_a_stb_q    <= 1'b0;
      mul_b_stb_q    <= 1'b0;
      mul_prod_ack_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      gnt_oh_q       <= gnt_oh_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      op_q           <= op_d;
      resp_data_q    <= resp_data_d;
      mul_a_stb_q    <= mul_a_stb_d;
      mul_b_stb_q    <= mul_b_stb_d;
      mul_prod_ack_q <= mul_prod_ack_d;
      busy_q         <= busy_d;
    end
  end

`ifdef FP_ARB_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q     <= '0;
      abort_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      abort_q    <= abort_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign mul_abort = abort_q;
  assign resp_err  = resp_err_q;
`else
  assign resp_err  = 1'b0;
`endif

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign mul_a        = op_q.a;
  assign mul_a_stb    = mul_a_stb_q;
  assign mul_b        = op_q.b;
  assign mul_b_stb    = mul_b_stb_q;
  assign mul_prod_ack = mul_prod_ack_q;
  assign busy         = busy_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a delay-configurable strobe/ack multiplier model.
module tb_fp_mul_arbiter;
  import fp_arb_pkg::*;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [127:0]  req_a = '0;
  logic [127:0]  req_b = '0;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready = '0;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [31:0]   mul_a, mul_b;
  logic          mul_a_stb, mul_b_stb;
  logic          mul_a_ack = 1'b0, mul_b_ack = 1'b0;
  logic [31:0]   mul_prod = '0;
  logic          mul_prod_stb = 1'b0;
  logic          mul_prod_ack;
  logic          busy;
  logic [1:0]    grant_id;
`ifdef FP_ARB_WDOG_EN
  logic          mul_abort;
`endif

  // Hand-computed IEEE-754 single products: 2*3, 1.5*2, -1*4, 0.5*0.5.
  logic [31:0] va [4] = '{32'h4000_0000, 32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000};
  logic [31:0] vb [4] = '{32'h4040_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F00_0000};
  logic [31:0] vp [4] = '{32'h40C0_0000, 32'h4040_0000, 32'hC080_0000, 32'h3E80_0000};

  int n_vec = 0, n_bad = 0;
  int a_dly = 0, b_dly = 0, p_dly = 2;
  int ac = 0, bc = 0, pc = 0;
  int xa = 0, xb = 0, xp = 0, ca = 0, cb = 0, n_abort = 0;
  logic [31:0] got_a = '0, got_b = '0;
  int w, ab0;

  fp_mul_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .mul_a        (mul_a),
    .mul_a_stb    (mul_a_stb),
    .mul_a_ack    (mul_a_ack),
    .mul_b        (mul_b),
    .mul_b_stb    (mul_b_stb),
    .mul_b_ack    (mul_b_ack),
    .mul_prod     (mul_prod),
    .mul_prod_stb (mul_prod_stb),
    .mul_prod_ack (mul_prod_ack),
`ifdef FP_ARB_WDOG_EN
    .mul_abort    (mul_abort),
`endif
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prod_of(input logic [31:0] a, input logic [31:0] b);
    prod_of = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++)
      if (va[i] == a && vb[i] == b) prod_of = vp[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfer monitor: counts handshakes and strobe-high cycles.
  always @(posedge clk) begin
    if (mul_a_stb && mul_a_ack) begin xa <= xa + 1; got_a <= mul_a; end
    if (mul_b_stb && mul_b_ack) begin xb <= xb + 1; got_b <= mul_b; end
    if (mul_prod_ack && mul_prod_stb) xp <= xp + 1;
    if (mul_a_stb) ca <= ca + 1;
    if (mul_b_stb) cb <= cb + 1;
`ifdef FP_ARB_WDOG_EN
    if (mul_abort) n_abort <= n_abort + 1;
`endif
  end

  // Multiplier model: acks after a programmable number of waiting cycles.
  always @(negedge clk) begin
    if (reset) begin
      mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_prod_stb = 1'b0;
      ac = 0; bc = 0; pc = 0;
    end else begin
      mul_a_ack = 1'b0;
      if (mul_a_stb) begin if (ac >= a_dly) mul_a_ack = 1'b1; else ac++; end else ac = 0;
      mul_b_ack = 1'b0;
      if (mul_b_stb) begin if (bc >= b_dly) mul_b_ack = 1'b1; else bc++; end else bc = 0;
      mul_prod_stb = 1'b0;
      if (mul_prod_ack) begin
        if (pc >= p_dly) begin mul_prod_stb = 1'b1; mul_prod = prod_of(got_a, got_b); end
        else pc++;
      end else pc = 0;
    end
  end

  task automatic run_op(input int g, input bit drop, input int rdly, input logic [3:0] late,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_xp,
                        output int waited);
    int xa0, xb0, xp0, ca0, cb0;
    logic [3:0] mask;
    mask   = 4'(1 << g);
    waited = 0;
    while (waited < 40 && req_ready == '0) begin @(negedge clk); waited++; end
    chk("req_ready", 32'(req_ready), 32'(mask));
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("a_stb_on_grant", 32'(mul_a_stb), 32'd1);
    chk("mul_a", mul_a, va[g]);
    xa0 = xa; xb0 = xb; xp0 = xp; ca0 = ca; cb0 = cb;
    if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 32'(req_ready), 32'd0);
    for (int c = 0; c < 300 && resp_valid == '0; c++) @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'(mask));
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", 32'(resp_err), 32'(exp_e));
    chk("a_xfers", 32'(xa - xa0), 32'd1);
    chk("b_xfers", 32'(xb - xb0), 32'd1);
    chk("p_xfers", 32'(xp - xp0), 32'(exp_xp));
    chk("a_seen", got_a, va[g]);
    chk("b_seen", got_b, vb[g]);
    chk("a_stb_cycles", 32'(ca - ca0), 32'(a_dly + 1));
    chk("b_stb_cycles", 32'(cb - cb0), 32'(b_dly + 1));
    resp_ready = ~mask;
    req_valid  = req_valid | late;
    for (int c = 0; c < rdly; c++) begin
      @(negedge clk);
      chk("resp_hold", 32'(resp_valid), 32'(mask));
      chk("no_grant_in_resp", 32'(req_ready), 32'd0);
    end
    resp_ready = mask;
    @(negedge clk);
    chk("resp_clear", 32'(resp_valid), 32'd0);
    chk("idle_after_resp", 32'(busy), 32'd0);
    resp_ready = '0;
  endtask

  initial begin
    req_a = {va[3], va[2], va[1], va[0]};
    req_b = {vb[3], vb[2], vb[1], vb[0]};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_a_stb", 32'(mul_a_stb), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request, then one with stalled acks and stalled resp_ready.
    req_valid = 4'b0001;
    run_op(0, 1'b1, 0, 4'b0000, vp[0], 1'b0, 1, w);
    chk("single_latency", 32'(w), 32'd1);
    a_dly = 5; b_dly = 5;
    req_valid = 4'b0010;
    run_op(1, 1'b1, 5, 4'b0000, vp[1], 1'b0, 1, w);
    a_dly = 0; b_dly = 0;

    // Async reset while waiting for the product.
    p_dly = 1000;
    req_valid = 4'b0001;
    for (int c = 0; c < 20 && !mul_prod_ack; c++) begin
      @(negedge clk);
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    chk("in_wait_prod", 32'(mul_prod_ack), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_prod_ack", 32'(mul_prod_ack), 32'd0);
    chk("arst_mul_a", mul_a, 32'd0);
    chk("arst_mul_b", mul_b, 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p_dly = 2;
    req_valid = 4'b0100;
    run_op(2, 1'b1, 0, 4'b0000, vp[2], 1'b0, 1, w);
    chk("post_reset_grant_wait", 32'(w), 32'd1);

    // Round-robin with every requester holding valid, pointer freshly reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) run_op(k % 4, 1'b0, 0, 4'b0000, vp[k % 4], 1'b0, 1, w);
    req_valid = 4'b0000;

    // Late requester shows up during RESP; granted the cycle after the handshake.
    req_valid = 4'b0001;
    run_op(0, 1'b1, 3, 4'b1000, vp[0], 1'b0, 1, w);
    run_op(3, 1'b1, 0, 4'b0000, vp[3], 1'b0, 1, w);
    chk("late_next_cycle", 32'(w), 32'd1);

`ifdef FP_ARB_WDOG_EN
    p_dly = 1000;
    ab0 = n_abort;
    req_valid = 4'b0001;
    run_op(0, 1'b1, 0, 4'b0000, FP_QNAN, 1'b1, 0, w);
    chk("abort_pulses", 32'(n_abort - ab0), 32'd1);
    p_dly = 2;
    req_valid = 4'b0010;
    run_op(1, 1'b1, 0, 4'b0000, vp[1], 1'b0, 1, w);
    chk("no_extra_abort", 32'(n_abort - ab0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
